// File: rtl/spad_arb.sv
// spad_arb: shares one spad read channel and one spad write channel between
// master 0 (systolic array) and master 1 (DMA). Reads and writes each have an
// independent two-way round-robin arbiter. Every accepted read pushes the
// issuing master ID into an in-order tag FIFO so the response can be routed
// back to its owner. All request/response paths are combinational.
`timescale 1ns/1ps
module spad_arb #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned RDATA_W = 256,
  parameter int unsigned WDATA_W = 256,
  parameter int unsigned OUTST   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // master 0 read address / read data
  input  logic                     m0_ar_valid_i,
  output logic                     m0_ar_ready_o,
  input  logic [ADDR_W-1:0]        m0_ar_addr_i,
  output logic                     m0_r_valid_o,
  input  logic                     m0_r_ready_i,
  output logic [RDATA_W-1:0]       m0_r_data_o,
  // master 1 read address / read data
  input  logic                     m1_ar_valid_i,
  output logic                     m1_ar_ready_o,
  input  logic [ADDR_W-1:0]        m1_ar_addr_i,
  output logic                     m1_r_valid_o,
  input  logic                     m1_r_ready_i,
  output logic [RDATA_W-1:0]       m1_r_data_o,
  // master write channels (address and data together)
  input  logic                     m0_aw_valid_i,
  output logic                     m0_aw_ready_o,
  input  logic [ADDR_W-1:0]        m0_aw_addr_i,
  input  logic [WDATA_W-1:0]       m0_aw_data_i,
  input  logic                     m1_aw_valid_i,
  output logic                     m1_aw_ready_o,
  input  logic [ADDR_W-1:0]        m1_aw_addr_i,
  input  logic [WDATA_W-1:0]       m1_aw_data_i,
  // spad side
  output logic                     s_ar_valid_o,
  input  logic                     s_ar_ready_i,
  output logic [ADDR_W-1:0]        s_ar_addr_o,
  input  logic                     s_r_valid_i,
  output logic                     s_r_ready_o,
  input  logic [RDATA_W-1:0]       s_r_data_i,
  output logic                     s_aw_valid_o,
  input  logic                     s_aw_ready_i,
  output logic [ADDR_W-1:0]        s_aw_addr_o,
  output logic [WDATA_W-1:0]       s_aw_data_o,
  // status
  output logic [$clog2(OUTST):0]   outst_cnt_o,
  output logic                     err_o
);

  localparam int unsigned IDX_W = $clog2(OUTST);
  localparam int unsigned PTR_W = IDX_W + 1;

  // registered state
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OUTST-1:0] tag_q, tag_d;
  logic             rd_pri_q, rd_pri_d;
  logic             wr_pri_q, wr_pri_d;
  logic             err_q, err_d;

  // combinational helpers
  logic [PTR_W-1:0] occ;
  logic             full;
  logic             empty;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             hd;
  logic             rd_both;
  logic             rd_win;
  logic             rd_push;
  logic             rd_pop;
  logic             wr_both;
  logic             wr_win;
  logic             wr_hs;

  // FIFO occupancy from the extra-bit pointers
  always_comb begin
    occ    = wr_ptr_q - rd_ptr_q;
    full   = (occ == PTR_W'(OUTST));
    empty  = (occ == '0);
    wr_idx = wr_ptr_q[IDX_W-1:0];
    rd_idx = rd_ptr_q[IDX_W-1:0];
    hd     = tag_q[rd_idx];
  end

  // Read arbitration: pointer breaks ties, a lone requester always wins
  always_comb begin
    rd_both       = m0_ar_valid_i & m1_ar_valid_i;
    rd_win        = rd_both ? rd_pri_q : m1_ar_valid_i;
    s_ar_valid_o  = (m0_ar_valid_i | m1_ar_valid_i) & ~full;
    s_ar_addr_o   = rd_win ? m1_ar_addr_i : m0_ar_addr_i;
    m0_ar_ready_o = m0_ar_valid_i & ~rd_win & s_ar_ready_i & ~full;
    m1_ar_ready_o = m1_ar_valid_i &  rd_win & s_ar_ready_i & ~full;
    rd_push       = s_ar_valid_o & s_ar_ready_i;
  end

  // Write arbitration: same scheme, no tag tracking
  always_comb begin
    wr_both       = m0_aw_valid_i & m1_aw_valid_i;
    wr_win        = wr_both ? wr_pri_q : m1_aw_valid_i;
    s_aw_valid_o  = m0_aw_valid_i | m1_aw_valid_i;
    s_aw_addr_o   = wr_win ? m1_aw_addr_i : m0_aw_addr_i;
    s_aw_data_o   = wr_win ? m1_aw_data_i : m0_aw_data_i;
    m0_aw_ready_o = m0_aw_valid_i & ~wr_win & s_aw_ready_i;
    m1_aw_ready_o = m1_aw_valid_i &  wr_win & s_aw_ready_i;
    wr_hs         = s_aw_valid_o & s_aw_ready_i;
  end

  // Response routing to the master named by the FIFO head; untagged responses stall
  always_comb begin
    m0_r_valid_o = s_r_valid_i & ~empty & ~hd;
    m1_r_valid_o = s_r_valid_i & ~empty &  hd;
    m0_r_data_o  = s_r_data_i;
    m1_r_data_o  = s_r_data_i;
    s_r_ready_o  = ~empty & (hd ? m1_r_ready_i : m0_r_ready_i);
    rd_pop       = s_r_valid_i & s_r_ready_o;
  end

  // Next-state: tag push/pop, round-robin pointer updates, sticky error
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tag_d    = tag_q;
    rd_pri_d = rd_pri_q;
    wr_pri_d = wr_pri_q;
    err_d    = err_q;
    if (rd_push) begin
      tag_d[wr_idx] = rd_win;
      wr_ptr_d      = wr_ptr_q + PTR_W'(1);
      if (rd_both) begin
        rd_pri_d = ~rd_win;
      end
    end
    if (rd_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (wr_hs && wr_both) begin
      wr_pri_d = ~wr_win;
    end
    if (s_r_valid_i && empty) begin
      err_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tag_q    <= '0;
      rd_pri_q <= 1'b0;
      wr_pri_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tag_q    <= tag_d;
      rd_pri_q <= rd_pri_d;
      wr_pri_q <= wr_pri_d;
      err_q    <= err_d;
    end
  end

  assign outst_cnt_o = occ;
  assign err_o       = err_q;

endmodule

// File: tb/tb_spad_arb.sv
// tb_spad_arb: directed bench for spad_arb with a queue-based spad read model.
`timescale 1ns/1ps
module tb_spad_arb;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 256;

  logic          clk;
  logic          rst_n;
  logic          m0_ar_valid_i, m0_ar_ready_o, m1_ar_valid_i, m1_ar_ready_o;
  logic [AW-1:0] m0_ar_addr_i, m1_ar_addr_i;
  logic          m0_r_valid_o, m0_r_ready_i, m1_r_valid_o, m1_r_ready_i;
  logic [DW-1:0] m0_r_data_o, m1_r_data_o;
  logic          m0_aw_valid_i, m0_aw_ready_o, m1_aw_valid_i, m1_aw_ready_o;
  logic [AW-1:0] m0_aw_addr_i, m1_aw_addr_i;
  logic [DW-1:0] m0_aw_data_i, m1_aw_data_i;
  logic          s_ar_valid_o, s_ar_ready_i;
  logic [AW-1:0] s_ar_addr_o;
  logic          s_r_valid_i, s_r_ready_o;
  logic [DW-1:0] s_r_data_i;
  logic          s_aw_valid_o, s_aw_ready_i;
  logic [AW-1:0] s_aw_addr_o;
  logic [DW-1:0] s_aw_data_o;
  logic [2:0]    outst_cnt_o;
  logic          err_o;

  spad_arb #(.ADDR_W(32), .RDATA_W(256), .WDATA_W(256), .OUTST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_ar_valid_i(m0_ar_valid_i), .m0_ar_ready_o(m0_ar_ready_o), .m0_ar_addr_i(m0_ar_addr_i),
    .m0_r_valid_o(m0_r_valid_o), .m0_r_ready_i(m0_r_ready_i), .m0_r_data_o(m0_r_data_o),
    .m1_ar_valid_i(m1_ar_valid_i), .m1_ar_ready_o(m1_ar_ready_o), .m1_ar_addr_i(m1_ar_addr_i),
    .m1_r_valid_o(m1_r_valid_o), .m1_r_ready_i(m1_r_ready_i), .m1_r_data_o(m1_r_data_o),
    .m0_aw_valid_i(m0_aw_valid_i), .m0_aw_ready_o(m0_aw_ready_o), .m0_aw_addr_i(m0_aw_addr_i),
    .m0_aw_data_i(m0_aw_data_i),
    .m1_aw_valid_i(m1_aw_valid_i), .m1_aw_ready_o(m1_aw_ready_o), .m1_aw_addr_i(m1_aw_addr_i),
    .m1_aw_data_i(m1_aw_data_i),
    .s_ar_valid_o(s_ar_valid_o), .s_ar_ready_i(s_ar_ready_i), .s_ar_addr_o(s_ar_addr_o),
    .s_r_valid_i(s_r_valid_i), .s_r_ready_o(s_r_ready_o), .s_r_data_i(s_r_data_i),
    .s_aw_valid_o(s_aw_valid_o), .s_aw_ready_i(s_aw_ready_i), .s_aw_addr_o(s_aw_addr_o),
    .s_aw_data_o(s_aw_data_o),
    .outst_cnt_o(outst_cnt_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [DW-1:0] rdata(input logic [AW-1:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  function automatic logic [DW-1:0] wdata(input logic [AW-1:0] a);
    return {8{a ^ 32'h0BAD_0000}};
  endfunction

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // spad read model: 1-cycle latency, in-order, can be stalled via model_en
  logic          model_en = 1'b0;
  logic          frc_rvalid = 1'b0;
  logic [AW-1:0] mq[$];
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      if (model_en && s_r_valid_i && s_r_ready_o && mq.size() != 0) void'(mq.pop_front());
      if (s_ar_valid_o && s_ar_ready_i) mq.push_back(s_ar_addr_o);
    end
    #1;
    s_r_valid_i = (model_en && mq.size() != 0) || frc_rvalid;
    s_r_data_i  = (mq.size() != 0) ? rdata(mq[0]) : '0;
  end

  // master request queues and observation logs
  logic [AW-1:0] q0[$], q1[$], aq0[$], aq1[$];
  logic [DW-1:0] got0[$], got1[$];
  logic [AW-1:0] wlog[$];
  int            grants[$], rids[$];
  int            peak;
  logic          m1_seen;

  task automatic clr();
    got0.delete(); got1.delete(); wlog.delete(); grants.delete(); rids.delete();
    peak = 0; m1_seen = 1'b0;
  endtask

  task automatic drive();
    m0_ar_valid_i = (q0.size() != 0);
    m0_ar_addr_i  = (q0.size() != 0) ? q0[0] : '0;
    m1_ar_valid_i = (q1.size() != 0);
    m1_ar_addr_i  = (q1.size() != 0) ? q1[0] : '0;
    m0_aw_valid_i = (aq0.size() != 0);
    m0_aw_addr_i  = (aq0.size() != 0) ? aq0[0] : '0;
    m0_aw_data_i  = wdata(m0_aw_addr_i);
    m1_aw_valid_i = (aq1.size() != 0);
    m1_aw_addr_i  = (aq1.size() != 0) ? aq1[0] : '0;
    m1_aw_data_i  = wdata(m1_aw_addr_i);
  endtask

  // run ncyc cycles: drive from queues, observe handshakes at negedge
  task automatic run(input int ncyc);
    logic       pb;
    logic [2:0] po;
    pb = 1'b0;
    po = '0;
    for (int c = 0; c < ncyc; c++) begin
      drive();
      @(negedge clk);
      if (pb) check_eq("pp_occ", DW'(outst_cnt_o), DW'(po));
      pb = s_ar_valid_o && s_ar_ready_i && s_r_valid_i && s_r_ready_o;
      po = outst_cnt_o;
      if (int'(outst_cnt_o) > peak) peak = int'(outst_cnt_o);
      if (m1_r_valid_o) m1_seen = 1'b1;
      if (m0_ar_valid_i && m0_ar_ready_o) begin grants.push_back(0); void'(q0.pop_front()); end
      if (m1_ar_valid_i && m1_ar_ready_o) begin grants.push_back(1); void'(q1.pop_front()); end
      if (m0_r_valid_o && m0_r_ready_i) begin got0.push_back(m0_r_data_o); rids.push_back(0); end
      if (m1_r_valid_o && m1_r_ready_i) begin got1.push_back(m1_r_data_o); rids.push_back(1); end
      if (s_aw_valid_o && s_aw_ready_i) begin
        wlog.push_back(s_aw_addr_o);
        check_eq("aw_data", s_aw_data_o, wdata(s_aw_addr_o));
      end
      if (m0_aw_valid_i && m0_aw_ready_o) void'(aq0.pop_front());
      if (m1_aw_valid_i && m1_aw_ready_o) void'(aq1.pop_front());
      @(posedge clk); #2;
    end
    drive();
  endtask

  task automatic chk_data(input string tag, input logic [DW-1:0] g[$], input logic [AW-1:0] ea[$]);
    check_eq({tag, "_cnt"}, DW'(g.size()), DW'(ea.size()));
    for (int i = 0; i < ea.size(); i++)
      check_eq(tag, (i < g.size()) ? g[i] : '0, rdata(ea[i]));
  endtask

  task automatic chk_ids(input string tag, input int g[$], input int e[$]);
    check_eq({tag, "_cnt"}, DW'(g.size()), DW'(e.size()));
    for (int i = 0; i < e.size(); i++)
      check_eq(tag, (i < g.size()) ? DW'(g[i]) : DW'(9), DW'(e[i]));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] ea[$];
    logic [AW-1:0] eb[$];
    int            ei[$];
    rst_n = 1'b0;
    s_ar_ready_i = 1'b1; s_aw_ready_i = 1'b1;
    m0_r_ready_i = 1'b1; m1_r_ready_i = 1'b1;
    clr();
    drive();
    do_reset();

    // reset state
    @(negedge clk);
    check_eq("rst_outst", DW'(outst_cnt_o), DW'(0));
    check_eq("rst_err", DW'(err_o), DW'(0));
    check_eq("rst_s_ar_valid", DW'(s_ar_valid_o), DW'(0));
    check_eq("rst_s_r_ready", DW'(s_r_ready_o), DW'(0));
    @(posedge clk); #2;

    // single master, three reads, 1-cycle spad latency
    model_en = 1'b1;
    clr();
    for (int i = 0; i < 3; i++) q0.push_back(32'h10 + 32'(i));
    run(6);
    ea.delete();
    for (int i = 0; i < 3; i++) ea.push_back(32'h10 + 32'(i));
    chk_data("t1_m0_data", got0, ea);
    check_eq("t1_m1_rvalid", DW'(m1_seen), DW'(0));
    check_eq("t1_peak", DW'(peak >= 1 && peak <= 2), DW'(1));

    // contention from reset on both ar and aw
    do_reset();
    clr();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(32'h100 + 32'(2 * i));  q1.push_back(32'h201 + 32'(2 * i));
      aq0.push_back(32'h300 + 32'(2 * i)); aq1.push_back(32'h401 + 32'(2 * i));
    end
    run(10);
    ei.delete();
    for (int i = 0; i < 6; i++) ei.push_back(i % 2);
    chk_ids("t2_rd_grants", grants, ei);
    chk_ids("t2_resp_order", rids, ei);
    ea.delete(); eb.delete();
    for (int i = 0; i < 3; i++) begin
      ea.push_back(32'h100 + 32'(2 * i)); eb.push_back(32'h201 + 32'(2 * i));
    end
    chk_data("t2_m0_data", got0, ea);
    chk_data("t2_m1_data", got1, eb);
    ea.delete();
    for (int i = 0; i < 3; i++) begin
      ea.push_back(32'h300 + 32'(2 * i)); ea.push_back(32'h401 + 32'(2 * i));
    end
    check_eq("t2_aw_cnt", DW'(wlog.size()), DW'(6));
    for (int i = 0; i < 6; i++) check_eq("t2_aw_order", DW'((i < wlog.size()) ? wlog[i] : '0), DW'(ea[i]));

    // full: stalled responses, five reads, only four accepted
    model_en = 1'b0;
    clr();
    for (int i = 0; i < 5; i++) q0.push_back(32'h500 + 32'(i));
    run(6);
    check_eq("t3_grants_full", DW'(grants.size()), DW'(4));
    @(negedge clk);
    check_eq("t3_s_ar_valid", DW'(s_ar_valid_o), DW'(0));
    check_eq("t3_m0_ar_ready", DW'(m0_ar_ready_o), DW'(0));
    check_eq("t3_outst", DW'(outst_cnt_o), DW'(4));
    @(posedge clk); #2;
    model_en = 1'b1;
    run(10);
    check_eq("t3_grants_all", DW'(grants.size()), DW'(5));
    ea.delete();
    for (int i = 0; i < 5; i++) ea.push_back(32'h500 + 32'(i));
    chk_data("t3_m0_data", got0, ea);
    check_eq("t3_outst_end", DW'(outst_cnt_o), DW'(0));

    // backpressure from m1 at the FIFO head
    clr();
    m1_r_ready_i = 1'b0;
    q1.push_back(32'h601);
    run(1);
    q0.push_back(32'h602);
    run(3);
    @(negedge clk);
    check_eq("t4_m1_rvalid", DW'(m1_r_valid_o), DW'(1));
    check_eq("t4_m0_rvalid", DW'(m0_r_valid_o), DW'(0));
    check_eq("t4_s_r_ready", DW'(s_r_ready_o), DW'(0));
    check_eq("t4_outst", DW'(outst_cnt_o), DW'(2));
    @(posedge clk); #2;
    m1_r_ready_i = 1'b1;
    run(4);
    ei.delete(); ei.push_back(1); ei.push_back(0);
    chk_ids("t4_resp_order", rids, ei);
    ea.delete(); ea.push_back(32'h601);
    chk_data("t4_m1_data", got1, ea);
    ea.delete(); ea.push_back(32'h602);
    chk_data("t4_m0_data", got0, ea);

    // steady push+pop at occupancy 2, ten mixed reads wrapping the pointers
    model_en = 1'b0;
    clr();
    q0.push_back(32'h700); q1.push_back(32'h701);
    run(2);
    @(negedge clk);
    check_eq("t5_occ2", DW'(outst_cnt_o), DW'(2));
    @(posedge clk); #2;
    model_en = 1'b1;
    @(posedge clk); #2;
    for (int i = 1; i < 5; i++) begin
      q0.push_back(32'h700 + 32'(2 * i)); q1.push_back(32'h701 + 32'(2 * i));
    end
    run(14);
    check_eq("t5_peak", DW'(peak), DW'(2));
    check_eq("t5_grants", DW'(grants.size()), DW'(10));
    chk_ids("t5_resp_vs_grant", rids, grants);
    ea.delete(); eb.delete();
    for (int i = 0; i < 5; i++) begin
      ea.push_back(32'h700 + 32'(2 * i)); eb.push_back(32'h701 + 32'(2 * i));
    end
    chk_data("t5_m0_data", got0, ea);
    chk_data("t5_m1_data", got1, eb);

    // untagged response raises sticky error
    model_en = 1'b0;
    frc_rvalid = 1'b1;
    @(posedge clk); #2;
    @(negedge clk);
    check_eq("t6_err_s_r_ready", DW'(s_r_ready_o), DW'(0));
    check_eq("t6_err_no_route", DW'(m0_r_valid_o | m1_r_valid_o), DW'(0));
    @(posedge clk); #2;
    frc_rvalid = 1'b0;
    @(negedge clk);
    check_eq("t6_err_set", DW'(err_o), DW'(1));
    @(posedge clk); #2;
    clr();
    q0.push_back(32'h800); q1.push_back(32'h801); q0.push_back(32'h802);
    run(3);
    @(negedge clk);
    check_eq("t6_outst3", DW'(outst_cnt_o), DW'(3));
    check_eq("t6_err_sticky", DW'(err_o), DW'(1));
    @(posedge clk); #2;

    // one-cycle reset mid-transaction
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_outst", DW'(outst_cnt_o), DW'(0));
    check_eq("t6_rst_err", DW'(err_o), DW'(0));
    @(posedge clk); #2;
    model_en = 1'b1;
    clr();
    q0.push_back(32'h900); q1.push_back(32'h901);
    aq0.push_back(32'hA00); aq1.push_back(32'hA01);
    run(5);
    ei.delete(); ei.push_back(0); ei.push_back(1);
    chk_ids("t6_rd_grants", grants, ei);
    check_eq("t6_aw_cnt", DW'(wlog.size()), DW'(2));
    check_eq("t6_aw_first", DW'((wlog.size() > 0) ? wlog[0] : '0), DW'(32'hA00));
    ea.delete(); ea.push_back(32'h900);
    chk_data("t6_m0_data", got0, ea);
    ea.delete(); ea.push_back(32'h901);
    chk_data("t6_m1_data", got1, ea);
    check_eq("t6_err_clean", DW'(err_o), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
